// File: rtl/ad9172_pkg.sv
// Shared types and constants for the AD9172 I/Q soft-start gate.
package ad9172_pkg;

  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 16;
  localparam int GW_DEF    = 17;

  localparam logic [GW_DEF-1:0] GAIN_UNITY = 17'h10000;

  localparam int LANE_BUS_W = LANES_DEF * DW_DEF;

  typedef enum logic [1:0] {
    ST_MUTE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } gate_state_e;

endpackage

// File: rtl/iq_gain_sat.sv
// One lane of gain scaling: signed multiply, round half up, saturate; two register stages.
import ad9172_pkg::*;

module iq_gain_sat #(
  parameter int DW = DW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic signed [DW-1:0] din_i,
  input  logic        [GW-1:0] gain_i,
  output logic signed [DW-1:0] dout_o
);

  localparam int PW = DW + GW;
  localparam logic signed [PW-1:0] SAT_HI = {{(GW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(GW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [PW-1:0] prod_p0_d, prod_p0_q;
  logic signed [DW-1:0] dout_p1_d, dout_p1_q;

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] bias;
    bias         = '0;
    bias[GW-2]   = 1'b1;
    return (p + bias) >>> (GW-1);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [PW-1:0] r);
    if (r > SAT_HI)      return SAT_HI[DW-1:0];
    else if (r < SAT_LO) return SAT_LO[DW-1:0];
    else                 return r[DW-1:0];
  endfunction

  // Stage 0: full-precision product with the gain treated as non-negative
  assign prod_p0_d = PW'(din_i) * PW'($signed({1'b0, gain_i}));

  // Stage 1: round, saturate back to sample width
  assign dout_p1_d = saturate(round_shift(prod_p0_q));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prod_p0_q <= '0;
      dout_p1_q <= '0;
    end else begin
      prod_p0_q <= prod_p0_d;
      dout_p1_q <= dout_p1_d;
    end
  end

  assign dout_o = dout_p1_q;

endmodule

// File: rtl/dac_iq_ramp_gate.sv
// Soft-start/soft-stop amplitude gate between the DDS I/Q outputs and the AD9172 JESD inputs.
import ad9172_pkg::*;

module dac_iq_ramp_gate #(
  parameter int LANES     = LANES_DEF,
  parameter int DW        = DW_DEF,
  parameter int GW        = GW_DEF,
  parameter bit HARD_MUTE = 1'b1
) (
  input  logic                clk_user_bufg,
  input  logic                rst_glb_n,
  input  logic                dac_ready,
  input  logic                tx_en,
  input  logic [15:0]         ramp_step,
  input  logic [LANES*DW-1:0] din_i,
  input  logic [LANES*DW-1:0] din_q,
  output logic [LANES*DW-1:0] dout_i,
  output logic [LANES*DW-1:0] dout_q,
  output logic [GW-1:0]       gain_o,
  output logic [1:0]          state_o,
  output logic                muted,
  output logic                ramp_done
);

  localparam logic [GW-1:0] UNITY = {1'b1, {(GW-1){1'b0}}};

  gate_state_e   state_q, state_d;
  logic [GW-1:0] gain_q, gain_d;
  logic          done_q, done_d;

  logic          go;
  logic [GW:0]   step_x, sum_up, diff_dn;
  logic [GW-1:0] up_gain, dn_gain;

  assign go = tx_en & dac_ready;

  // Arithmetic carried one bit wider so the clamp sees overflow/underflow directly
  assign step_x  = (ramp_step == 16'd0) ? (GW+1)'(1) : (GW+1)'(ramp_step);
  assign sum_up  = {1'b0, gain_q} + step_x;
  assign diff_dn = {1'b0, gain_q} - step_x;
  assign up_gain = (sum_up >= {1'b0, UNITY}) ? UNITY : sum_up[GW-1:0];
  assign dn_gain = diff_dn[GW] ? '0 : diff_dn[GW-1:0];

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_MUTE: begin
        gain_d = '0;
        if (go) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!go) begin
          state_d = ST_RAMP_DOWN;
        end else begin
          gain_d = up_gain;
          if (up_gain == UNITY) begin
            state_d = ST_ON;
            done_d  = 1'b1;
          end
        end
      end
      ST_ON: begin
        gain_d = UNITY;
        if (!go) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (go) begin
          state_d = ST_RAMP_UP;
        end else begin
          gain_d = dn_gain;
          if (dn_gain == '0) begin
            state_d = ST_MUTE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_MUTE;
    endcase
    // Link loss overrides everything: silent drop to mute, no completion pulse
    if (HARD_MUTE && !dac_ready) begin
      state_d = ST_MUTE;
      gain_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_user_bufg) begin
    if (!rst_glb_n) begin
      state_q <= ST_MUTE;
      gain_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      done_q  <= done_d;
    end
  end

  assign gain_o    = gain_q;
  assign state_o   = state_q;
  assign muted     = (state_q == ST_MUTE);
  assign ramp_done = done_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    iq_gain_sat #(.DW(DW), .GW(GW)) u_i (
      .clk_i   (clk_user_bufg),
      .rst_n_i (rst_glb_n),
      .din_i   (din_i[l*DW +: DW]),
      .gain_i  (gain_q),
      .dout_o  (dout_i[l*DW +: DW])
    );
    iq_gain_sat #(.DW(DW), .GW(GW)) u_q (
      .clk_i   (clk_user_bufg),
      .rst_n_i (rst_glb_n),
      .din_i   (din_q[l*DW +: DW]),
      .gain_i  (gain_q),
      .dout_o  (dout_q[l*DW +: DW])
    );
  end

endmodule
